// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the counter width helper. Used by the RTL and the testbench.
package usr_pkg;

  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;
  localparam logic [1:0] USR_SHL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  // Bits needed to hold a shift count from 0 to n inclusive.
  function automatic int unsigned usr_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/usr_frame_cnt.sv
// Saturating shift counter with a one-cycle frame_done pulse when the count
// first reaches N.
module usr_frame_cnt
  import usr_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      shift_en,
  input  logic                      load,
  output logic [usr_cnt_w(N)-1:0]   cnt,
  output logic                      frame_done
);

  localparam int unsigned CW = usr_cnt_w(N);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_done_q, frame_done_d;

  // Next count and pulse; load wins, saturated shifts do not re-pulse.
  always_comb begin
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (load) begin
      cnt_d = '0;
    end else if (shift_en) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
      frame_done_d = (cnt_q == CNT_LAST);
    end
  end

  // Count and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cnt        = cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with a frame counter. Optional rotate mode is enabled by defining
// USR_ROTATE_EN; otherwise the rot port is present but ignored.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic                      si_r,
  input  logic                      si_l,
  input  logic                      rot,
  input  logic [N-1:0]              pin,
  output logic [N-1:0]              so,
  output logic                      sout,
  output logic [usr_cnt_w(N)-1:0]   cnt,
  output logic                      frame_done
);

  logic [N-1:0] so_q, so_d;
  logic         shift_en;
  logic         load;
  logic         in_r;
  logic         in_l;

`ifdef USR_ROTATE_EN
  // Rotation feeds the exiting bit back in place of the serial input.
  assign in_r = rot ? so_q[0]   : si_r;
  assign in_l = rot ? so_q[N-1] : si_l;
`else
  logic rot_unused;
  assign rot_unused = rot;
  assign in_r = si_r;
  assign in_l = si_l;
`endif

  // Decode mode into next register value and counter controls.
  always_comb begin
    so_d     = so_q;
    shift_en = 1'b0;
    load     = 1'b0;
    case (mode)
      USR_SHR: begin
        so_d     = {in_r, so_q[N-1:1]};
        shift_en = 1'b1;
      end
      USR_SHL: begin
        so_d     = {so_q[N-2:0], in_l};
        shift_en = 1'b1;
      end
      USR_LOAD: begin
        so_d = pin;
        load = 1'b1;
      end
      default: begin
        so_d = so_q;
      end
    endcase
  end

  // Data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      so_q <= '0;
    end else begin
      so_q <= so_d;
    end
  end

  usr_frame_cnt #(
    .N (N)
  ) u_frame_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (shift_en),
    .load       (load),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  assign so   = so_q;
  assign sout = (mode == USR_SHR) ? so_q[0] : so_q[N-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (N=6) using a scoreboard queue of
// expected register states. Covers rotate behaviour when USR_ROTATE_EN is set.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int unsigned N  = 6;
  localparam int unsigned CW = usr_cnt_w(N);
`ifdef USR_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0]  so;
    logic [CW-1:0] cnt;
    logic          fd;
    logic          sout;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [1:0]    mode;
  logic          si_r;
  logic          si_l;
  logic          rot;
  logic [N-1:0]  pin;
  logic [N-1:0]  so;
  logic          sout;
  logic [CW-1:0] cnt;
  logic          frame_done;

  exp_t          exp_q[$];
  logic [N-1:0]  so_m;
  logic [CW-1:0] cnt_m;
  logic          fd_m;
  int            n_pass;
  int            n_total;

  univ_shift_reg #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .si_r       (si_r),
    .si_l       (si_l),
    .rot        (rot),
    .pin        (pin),
    .so         (so),
    .sout       (sout),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    so_m  = '0;
    cnt_m = '0;
    fd_m  = 1'b0;
  endtask

  // Apply one cycle of inputs, predict the result, then sample after the edge.
  task automatic drive_cycle(input logic [1:0] m, input logic sr, input logic sl,
                             input logic r, input logic [N-1:0] p);
    exp_t e;
    logic b;
    mode = m; si_r = sr; si_l = sl; rot = r; pin = p;
    fd_m = 1'b0;
    case (m)
      USR_SHR: begin
        b = (ROT_EN && r) ? so_m[0] : sr;
        fd_m = (int'(cnt_m) == N - 1);
        so_m = {b, so_m[N-1:1]};
        if (int'(cnt_m) < N) cnt_m = cnt_m + CW'(1);
      end
      USR_SHL: begin
        b = (ROT_EN && r) ? so_m[N-1] : sl;
        fd_m = (int'(cnt_m) == N - 1);
        so_m = {so_m[N-2:0], b};
        if (int'(cnt_m) < N) cnt_m = cnt_m + CW'(1);
      end
      USR_LOAD: begin
        so_m  = p;
        cnt_m = '0;
      end
      default: ;
    endcase
    e.so   = so_m;
    e.cnt  = cnt_m;
    e.fd   = fd_m;
    e.sout = (m == USR_SHR) ? so_m[0] : so_m[N-1];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = USR_HOLD; si_r = 1'b0; si_l = 1'b0; rot = 1'b0; pin = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (so !== '0 || cnt !== '0 || frame_done !== 1'b0) begin
      $display("FAIL reset: so=%b cnt=%0d fd=%b, want so=0 cnt=0 fd=0", so, cnt, frame_done);
    end else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_shift_right();
    exp_t e;
    logic [N-1:0] pat;
    int pulses;
    pat = 6'b010101;
    pulses = 0;
    for (int i = 0; i < N; i++) begin
      drive_cycle(USR_SHR, pat[i], 1'b0, 1'b0, '0);
      e = exp_q.pop_front();
      if (frame_done === 1'b1) pulses++;
      n_total++;
      if (so !== e.so || cnt !== e.cnt || frame_done !== e.fd || sout !== e.sout) begin
        $display("FAIL shr step %0d: so=%b cnt=%0d fd=%b sout=%b, want so=%b cnt=%0d fd=%b sout=%b",
                 i, so, cnt, frame_done, sout, e.so, e.cnt, e.fd, e.sout);
      end else n_pass++;
    end
    n_total++;
    if (so !== 6'b010101 || cnt !== CW'(6) || frame_done !== 1'b1 || pulses != 1) begin
      $display("FAIL shr frame: so=%b cnt=%0d fd=%b pulses=%0d, want so=010101 cnt=6 fd=1 pulses=1",
               so, cnt, frame_done, pulses);
    end else n_pass++;
  endtask

  task automatic test_shift_left();
    exp_t e;
    drive_cycle(USR_LOAD, 1'b0, 1'b0, 1'b1, 6'b110011);
    e = exp_q.pop_front();
    n_total++;
    if (so !== e.so || cnt !== e.cnt || frame_done !== e.fd) begin
      $display("FAIL shl load: so=%b cnt=%0d fd=%b, want so=%b cnt=%0d fd=%b",
               so, cnt, frame_done, e.so, e.cnt, e.fd);
    end else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(USR_SHL, 1'b0, 1'b1, 1'b0, '0);
      e = exp_q.pop_front();
      n_total++;
      if (so !== e.so || cnt !== e.cnt || frame_done !== e.fd || sout !== e.sout) begin
        $display("FAIL shl step %0d: so=%b cnt=%0d fd=%b sout=%b, want so=%b cnt=%0d fd=%b sout=%b",
                 i, so, cnt, frame_done, sout, e.so, e.cnt, e.fd, e.sout);
      end else n_pass++;
    end
    n_total++;
    if (so !== 6'b001111 || cnt !== CW'(2) || sout !== 1'b0) begin
      $display("FAIL shl result: so=%b cnt=%0d sout=%b, want so=001111 cnt=2 sout=0", so, cnt, sout);
    end else n_pass++;
  endtask

  task automatic test_rotate();
    exp_t e;
    int pulses;
    pulses = 0;
    drive_cycle(USR_LOAD, 1'b0, 1'b0, 1'b1, 6'b000001);
    void'(exp_q.pop_front());
`ifdef USR_ROTATE_EN
    for (int i = 0; i < N; i++) begin
      drive_cycle(USR_SHR, 1'b0, 1'b0, 1'b1, '0);
      e = exp_q.pop_front();
      if (frame_done === 1'b1) pulses++;
      n_total++;
      if (so !== e.so || cnt !== e.cnt || frame_done !== e.fd) begin
        $display("FAIL rot step %0d: so=%b cnt=%0d fd=%b, want so=%b cnt=%0d fd=%b",
                 i, so, cnt, frame_done, e.so, e.cnt, e.fd);
      end else n_pass++;
    end
    n_total++;
    if (so !== 6'b000001 || pulses != 1) begin
      $display("FAIL rot frame: so=%b pulses=%0d, want so=000001 pulses=1", so, pulses);
    end else n_pass++;
    drive_cycle(USR_SHR, 1'b0, 1'b0, 1'b1, '0);
    void'(exp_q.pop_front());
    n_total++;
    if (so !== 6'b100000 || cnt !== CW'(6) || frame_done !== 1'b0) begin
      $display("FAIL rot 7th: so=%b cnt=%0d fd=%b, want so=100000 cnt=6 fd=0", so, cnt, frame_done);
    end else n_pass++;
`else
    drive_cycle(USR_SHR, 1'b0, 1'b0, 1'b1, '0);
    e = exp_q.pop_front();
    if (frame_done === 1'b1) pulses++;
    n_total++;
    if (so !== 6'b000000 || so !== e.so || cnt !== CW'(1) || pulses != 0) begin
      $display("FAIL norot: so=%b cnt=%0d fd=%b, want so=000000 cnt=1 fd=0", so, cnt, frame_done);
    end else n_pass++;
    drive_cycle(USR_SHL, 1'b0, 1'b1, 1'b1, '0);
    e = exp_q.pop_front();
    n_total++;
    if (so !== 6'b000001 || so !== e.so || cnt !== e.cnt) begin
      $display("FAIL norot shl: so=%b cnt=%0d, want so=000001 cnt=%0d", so, cnt, e.cnt);
    end else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive_cycle(USR_LOAD, 1'b0, 1'b0, 1'b0, 6'b111000);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive_cycle(USR_SHL, 1'b1, 1'b0, 1'b0, '0);
      void'(exp_q.pop_front());
    end
    n_total++;
    if (cnt !== CW'(3)) begin
      $display("FAIL areset pre: cnt=%0d, want 3", cnt);
    end else n_pass++;
    rst_n = 1'b0;
    #3;
    n_total++;
    if (so !== '0 || cnt !== '0 || frame_done !== 1'b0) begin
      $display("FAIL areset immediate: so=%b cnt=%0d fd=%b, want so=0 cnt=0 fd=0", so, cnt, frame_done);
    end else n_pass++;
    rst_n = 1'b1;
    model_reset();
    drive_cycle(USR_SHR, 1'b1, 1'b0, 1'b0, '0);
    e = exp_q.pop_front();
    n_total++;
    if (cnt !== CW'(1) || so !== 6'b100000 || so !== e.so || cnt !== e.cnt) begin
      $display("FAIL areset post: so=%b cnt=%0d, want so=100000 cnt=1", so, cnt);
    end else n_pass++;
  endtask

  task automatic test_hold();
    exp_t e;
    int pulses;
    pulses = 0;
    drive_cycle(USR_LOAD, 1'b0, 1'b0, 1'b0, 6'b101010);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive_cycle(USR_HOLD, 1'b1, 1'b1, 1'b1, 6'b010101);
      e = exp_q.pop_front();
      if (frame_done !== 1'b0) pulses++;
      n_total++;
      if (so !== 6'b101010 || cnt !== '0 || so !== e.so || cnt !== e.cnt || sout !== e.sout) begin
        $display("FAIL hold step %0d: so=%b cnt=%0d sout=%b, want so=101010 cnt=0 sout=%b",
                 i, so, cnt, sout, e.sout);
      end else n_pass++;
    end
    n_total++;
    if (pulses != 0) begin
      $display("FAIL hold pulses: got %0d, want 0", pulses);
    end else n_pass++;
  endtask

  task automatic test_x_input();
    exp_t e;
    drive_cycle(USR_LOAD, 1'b0, 1'b0, 1'b0, 6'b000000);
    void'(exp_q.pop_front());
    drive_cycle(USR_SHR, 1'bx, 1'b0, 1'b0, '0);
    e = exp_q.pop_front();
    n_total++;
    if (so !== e.so || $isunknown(cnt) || $isunknown(frame_done) || cnt !== CW'(1)) begin
      $display("FAIL xin: so=%b cnt=%b fd=%b, want so=%b cnt=1 fd=0", so, cnt, frame_done, e.so);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [1:0] m;
    drive_cycle(USR_LOAD, 1'b0, 1'b0, 1'b0, 6'(32'h2d));
    void'(exp_q.pop_front());
    for (int i = 0; i < 40; i++) begin
      if (i == 20) m = USR_LOAD;
      else m = ($urandom_range(0, 3) == 0) ? USR_HOLD : (($urandom_range(0, 1) == 0) ? USR_SHR : USR_SHL);
      drive_cycle(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), N'($urandom));
      e = exp_q.pop_front();
      n_total++;
      if (so !== e.so || cnt !== e.cnt || frame_done !== e.fd || sout !== e.sout) begin
        $display("FAIL b2b step %0d mode=%b: so=%b cnt=%0d fd=%b sout=%b, want so=%b cnt=%0d fd=%b sout=%b",
                 i, m, so, cnt, frame_done, sout, e.so, e.cnt, e.fd, e.sout);
      end else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_shift_right();
    test_shift_left();
    test_rotate();
    test_async_reset();
    test_hold();
    test_x_input();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
